// File: rtl/prach_mixer.sv
// PRACH mixer: delays the sample stream to line up with the NCO, multiplies by
// e^-jphi, rounds and saturates back to fi(1,16,15), and supervises alignment.
// Optional error event counter is built when PRACH_MIXER_ERR_CNT_EN is defined.
module prach_mixer #(
    parameter int DATA_DLY = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] din_i,
    input  logic signed [15:0] din_q,
    input  logic               din_dv,
    input  logic [7:0]         din_chn,
    input  logic               sync_in,
    input  logic signed [15:0] nco_cos,
    input  logic signed [15:0] nco_sin,
    input  logic               nco_dv,
    input  logic [7:0]         nco_chn,
    input  logic               nco_sync,
    output logic signed [15:0] dout_i,
    output logic signed [15:0] dout_q,
    output logic               dout_dv,
    output logic [7:0]         dout_chn,
    output logic               sync_out,
    output logic               err_align,
    output logic [15:0]        err_cnt
);

    typedef enum logic [1:0] {WAIT_SYNC, RUN, ERR} state_t;

    state_t state, state_nxt;

    logic signed [15:0] dly_i [DATA_DLY];
    logic signed [15:0] dly_q [DATA_DLY];
    logic               dly_dv [DATA_DLY];
    logic [7:0]         dly_chn [DATA_DLY];
    logic               dly_sync [DATA_DLY];

    logic signed [15:0] d_i, d_q;
    logic               d_dv, d_sync;
    logic [7:0]         d_chn;

    logic mismatch, aligned_sync, accept, count_err;

    logic signed [31:0] p_ic, p_qs, p_qc, p_is;
    logic               s1_dv, s1_sync;
    logic [7:0]         s1_chn;
    logic signed [32:0] sum_i, sum_q;
    logic               s2_dv, s2_sync;
    logic [7:0]         s2_chn;

    // Only the low three channel bits take part in the alignment check.
    logic unused_nco_chn_hi;
    assign unused_nco_chn_hi = ^nco_chn[7:3];

    assign d_i    = dly_i[DATA_DLY-1];
    assign d_q    = dly_q[DATA_DLY-1];
    assign d_dv   = dly_dv[DATA_DLY-1];
    assign d_chn  = dly_chn[DATA_DLY-1];
    assign d_sync = dly_sync[DATA_DLY-1];

    // Shift register that delays the sample side to match NCO latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DATA_DLY; k++) begin
                dly_i[k]    <= '0;
                dly_q[k]    <= '0;
                dly_dv[k]   <= 1'b0;
                dly_chn[k]  <= '0;
                dly_sync[k] <= 1'b0;
            end
        end else begin
            dly_i[0]    <= din_i;
            dly_q[0]    <= din_q;
            dly_dv[0]   <= din_dv;
            dly_chn[0]  <= din_chn;
            dly_sync[0] <= sync_in;
            for (int k = 1; k < DATA_DLY; k++) begin
                dly_i[k]    <= dly_i[k-1];
                dly_q[k]    <= dly_q[k-1];
                dly_dv[k]   <= dly_dv[k-1];
                dly_chn[k]  <= dly_chn[k-1];
                dly_sync[k] <= dly_sync[k-1];
            end
        end
    end

    // Alignment checks between the delayed samples and the NCO side.
    always_comb begin
        mismatch = (d_dv != nco_dv) || (d_sync != nco_sync) ||
                   (d_dv && nco_dv && (d_chn[2:0] != nco_chn[2:0]));
        aligned_sync = d_sync && nco_sync && !mismatch;
        accept       = !mismatch && ((state == RUN) || aligned_sync);
        count_err    = mismatch && (state != WAIT_SYNC);
    end

    // Next-state logic; a mismatch always outranks a coincident sync.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_SYNC: if (aligned_sync) state_nxt = RUN;
            RUN:       if (mismatch)     state_nxt = ERR;
            ERR:       if (aligned_sync) state_nxt = RUN;
            default:                     state_nxt = WAIT_SYNC;
        endcase
    end

    // Alignment state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_SYNC;
        else        state <= state_nxt;
    end

    // Stage 1: full-precision products; valid is gated by the alignment state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_ic    <= '0;
            p_qs    <= '0;
            p_qc    <= '0;
            p_is    <= '0;
            s1_dv   <= 1'b0;
            s1_chn  <= '0;
            s1_sync <= 1'b0;
        end else begin
            p_ic    <= d_i * nco_cos;
            p_qs    <= d_q * nco_sin;
            p_qc    <= d_q * nco_cos;
            p_is    <= d_i * nco_sin;
            s1_dv   <= d_dv && accept;
            s1_chn  <= d_chn;
            s1_sync <= d_sync;
        end
    end

    // Stage 2: 33-bit sums implementing the e^-jphi rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_i   <= '0;
            sum_q   <= '0;
            s2_dv   <= 1'b0;
            s2_chn  <= '0;
            s2_sync <= 1'b0;
        end else begin
            sum_i   <= 33'(p_ic) + 33'(p_qs);
            sum_q   <= 33'(p_qc) - 33'(p_is);
            s2_dv   <= s1_dv;
            s2_chn  <= s1_chn;
            s2_sync <= s1_sync;
        end
    end

    // Round half up at bit 13, drop 14 fraction bits and clamp to 16 bits.
    function automatic logic signed [15:0] round_sat(input logic signed [32:0] s);
        logic signed [33:0] r;
        r = 34'(s) + 34'sd8192;
        r = r >>> 14;
        if (r > 34'sd32767)
            return 16'sh7fff;
        else if (r < -34'sd32768)
            return 16'sh8000;
        else
            return r[15:0];
    endfunction

    // Stage 3: output register; data holds whenever the output is not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_i   <= '0;
            dout_q   <= '0;
            dout_dv  <= 1'b0;
            dout_chn <= '0;
            sync_out <= 1'b0;
        end else begin
            if (s2_dv) begin
                dout_i <= round_sat(sum_i);
                dout_q <= round_sat(sum_q);
            end
            dout_dv  <= s2_dv;
            dout_chn <= s2_chn;
            sync_out <= s2_sync;
        end
    end

    // Sticky flag raised by the first mismatch seen outside WAIT_SYNC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         err_align <= 1'b0;
        else if (count_err) err_align <= 1'b1;
    end

`ifdef PRACH_MIXER_ERR_CNT_EN
    // Saturating count of mismatch cycles outside WAIT_SYNC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (count_err && (err_cnt != 16'hffff))
            err_cnt <= err_cnt + 16'd1;
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_prach_mixer.sv
// Testbench for prach_mixer: directed spec vectors plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_prach_mixer;

    localparam int DLY = 4;
`ifdef PRACH_MIXER_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
        logic               dv;
        logic [7:0]         chn;
        logic               sync;
    } samp_t;

    typedef struct packed {
        logic signed [15:0] c;
        logic signed [15:0] s;
        logic               dv;
        logic [7:0]         chn;
        logic               sync;
    } nco_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] din_i, din_q, nco_cos, nco_sin;
    logic               din_dv, sync_in, nco_dv, nco_sync;
    logic [7:0]         din_chn, nco_chn;
    logic signed [15:0] dout_i, dout_q;
    logic               dout_dv, sync_out, err_align;
    logic [7:0]         dout_chn;
    logic [15:0]        err_cnt;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model state
    samp_t din_hist[$];
    nco_t  nco_pend[$];
    samp_t exp_pipe[$];
    int    mstate;          // 0 waiting for sync, 1 running, 2 error
    logic  exp_err;
    logic [15:0] exp_cnt;
    samp_t exp_out;

    always #5 clk = ~clk;

    prach_mixer #(.DATA_DLY(DLY)) dut (
        .clk(clk), .rst_n(rst_n),
        .din_i(din_i), .din_q(din_q), .din_dv(din_dv), .din_chn(din_chn), .sync_in(sync_in),
        .nco_cos(nco_cos), .nco_sin(nco_sin), .nco_dv(nco_dv), .nco_chn(nco_chn), .nco_sync(nco_sync),
        .dout_i(dout_i), .dout_q(dout_q), .dout_dv(dout_dv), .dout_chn(dout_chn), .sync_out(sync_out),
        .err_align(err_align), .err_cnt(err_cnt)
    );

    function automatic logic [15:0] scale(input longint acc);
        longint t, r;
        t = acc + 8192;
        if (t >= 0) r = t / 16384;
        else        r = -((-t + 16383) / 16384);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string ph);
        check({ph, " dout_i"},    dout_i,          exp_out.i);
        check({ph, " dout_q"},    dout_q,          exp_out.q);
        check({ph, " dout_dv"},   16'(dout_dv),    16'(exp_out.dv));
        check({ph, " dout_chn"},  16'(dout_chn),   16'(exp_out.chn));
        check({ph, " sync_out"},  16'(sync_out),   16'(exp_out.sync));
        check({ph, " err_align"}, 16'(err_align),  16'(exp_err));
        check({ph, " err_cnt"},   err_cnt,         CNT_EN ? exp_cnt : 16'd0);
    endtask

    task automatic modelReset();
        din_hist.delete();
        nco_pend.delete();
        exp_pipe.delete();
        for (int k = 0; k < DLY; k++) begin
            din_hist.push_back('0);
            nco_pend.push_back('0);
        end
        exp_pipe.push_back('0);
        exp_pipe.push_back('0);
        mstate  = 0;
        exp_err = 1'b0;
        exp_cnt = '0;
        exp_out = '0;
    endtask

    // Drives one sample and the NCO word meant for it; the NCO word reaches
    // the DUT DLY cycles later, when the sample emerges from the delay line.
    task automatic applyStimulus(input samp_t s, input nco_t n);
        samp_t d, r, v;
        nco_t  nc;
        logic  mism, aligned, accept;
        longint acc_i, acc_q;
        din_hist.push_back(s);
        nco_pend.push_back(n);
        d  = din_hist.pop_front();
        nc = nco_pend.pop_front();
        din_i = s.i; din_q = s.q; din_dv = s.dv; din_chn = s.chn; sync_in = s.sync;
        nco_cos = nc.c; nco_sin = nc.s; nco_dv = nc.dv; nco_chn = nc.chn; nco_sync = nc.sync;

        mism = (d.dv != nc.dv) || (d.sync != nc.sync) ||
               (d.dv && nc.dv && (d.chn[2:0] != nc.chn[2:0]));
        aligned = d.sync && nc.sync && !mism;
        accept  = !mism && (mstate == 1 || aligned);
        if (mism && mstate != 0) begin
            exp_err = 1'b1;
            if (exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
        end
        if (mstate == 0 && aligned)      mstate = 1;
        else if (mstate == 1 && mism)    mstate = 2;
        else if (mstate == 2 && aligned) mstate = 1;

        acc_i = longint'($signed(d.i)) * longint'($signed(nc.c)) +
                longint'($signed(d.q)) * longint'($signed(nc.s));
        acc_q = longint'($signed(d.q)) * longint'($signed(nc.c)) -
                longint'($signed(d.i)) * longint'($signed(nc.s));
        r.i    = scale(acc_i);
        r.q    = scale(acc_q);
        r.dv   = d.dv && accept;
        r.chn  = d.chn;
        r.sync = d.sync;
        exp_pipe.push_back(r);

        @(posedge clk);
        #1;
        v = exp_pipe.pop_front();
        if (v.dv) begin
            exp_out.i = v.i;
            exp_out.q = v.q;
        end
        exp_out.dv   = v.dv;
        exp_out.chn  = v.chn;
        exp_out.sync = v.sync;
        checkOutput("cycle");
    endtask

    function automatic samp_t randSamp(input logic sync);
        samp_t s;
        s.i    = 16'($urandom);
        s.q    = 16'($urandom);
        s.dv   = ($urandom_range(0, 3) != 0);
        s.chn  = 8'($urandom_range(0, 7));
        s.sync = sync;
        return s;
    endfunction

    function automatic nco_t alignedNco(input samp_t s);
        nco_t n;
        n.c    = 16'($urandom);
        n.s    = 16'($urandom);
        n.dv   = s.dv;
        n.chn  = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), s.chn[2:0]};
        n.sync = s.sync;
        return n;
    endfunction

    // corrupt: 0 none, 1 channel, 2 valid, 3 sync
    task automatic randomStep(input logic sync, input int corrupt);
        samp_t s;
        nco_t  n;
        s = randSamp(sync);
        n = alignedNco(s);
        if (corrupt == 1) n.chn[2:0] = n.chn[2:0] + 3'd1;
        if (corrupt == 2) n.dv = ~n.dv;
        if (corrupt == 3) n.sync = ~n.sync;
        applyStimulus(s, n);
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) applyStimulus('0, '0);
    endtask

    task automatic alignedSync();
        samp_t s;
        s = randSamp(1'b1);
        s.dv = 1'b1;
        applyStimulus(s, alignedNco(s));
    endtask

    initial begin
        samp_t s;
        nco_t  n;
        rst_n = 1'b0;
        din_i = '0; din_q = '0; din_dv = 1'b0; din_chn = '0; sync_in = 1'b0;
        nco_cos = '0; nco_sin = '0; nco_dv = 1'b0; nco_chn = '0; nco_sync = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst_n = 1'b1;

        // Startup: traffic before any aligned sync, then a sync with a dv mismatch
        $display("[TB] startup");
        repeat (6) randomStep(1'b0, 0);
        s = randSamp(1'b1);
        s.dv = 1'b1;
        n = alignedNco(s);
        n.dv = 1'b0;
        applyStimulus(s, n);
        idle(DLY + 2);
        check("startup sync_out", 16'(sync_out), 16'd1);
        check("startup dout_dv", 16'(dout_dv), 16'd0);
        idle(3);

        // Pass-through on the entering aligned sync
        $display("[TB] pass-through");
        applyStimulus('{i: 16'sd16384, q: 16'sd0, dv: 1'b1, chn: 8'd3, sync: 1'b1},
                      '{c: 16'sd16384, s: 16'sd0, dv: 1'b1, chn: 8'd3, sync: 1'b1});
        idle(DLY + 2);
        check("pass dout_i", dout_i, 16'd16384);
        check("pass dout_q", dout_q, 16'd0);
        check("pass dout_chn", 16'(dout_chn), 16'd3);
        check("pass dout_dv", 16'(dout_dv), 16'd1);

        // Saturation
        applyStimulus('{i: 16'sd32767, q: 16'sd32767, dv: 1'b1, chn: 8'd1, sync: 1'b0},
                      '{c: 16'sd16384, s: -16'sd16384, dv: 1'b1, chn: 8'd1, sync: 1'b0});
        idle(DLY + 2);
        check("sat dout_i", dout_i, 16'd0);
        check("sat dout_q", dout_q, 16'd32767);

        // Rounding, positive and negative
        applyStimulus('{i: 16'sd3, q: 16'sd0, dv: 1'b1, chn: 8'd2, sync: 1'b0},
                      '{c: 16'sd8192, s: 16'sd0, dv: 1'b1, chn: 8'd2, sync: 1'b0});
        idle(DLY + 2);
        check("round pos dout_i", dout_i, 16'd2);
        applyStimulus('{i: -16'sd3, q: 16'sd0, dv: 1'b1, chn: 8'd2, sync: 1'b0},
                      '{c: 16'sd8192, s: 16'sd0, dv: 1'b1, chn: 8'd2, sync: 1'b0});
        idle(DLY + 2);
        check("round neg dout_i", dout_i, 16'hffff);

        // Random aligned traffic in RUN
        $display("[TB] random aligned");
        for (int k = 0; k < 150; k++) randomStep($urandom_range(0, 15) == 0, 0);
        check("run err_align", 16'(err_align), 16'd0);

        // Channel mismatch drives the block into ERR
        $display("[TB] channel mismatch");
        applyStimulus('{i: 16'sd1000, q: -16'sd2000, dv: 1'b1, chn: 8'd4, sync: 1'b0},
                      '{c: 16'sd4096, s: 16'sd4096, dv: 1'b1, chn: 8'd5, sync: 1'b0});
        idle(DLY + 2);
        check("chn dout_dv", 16'(dout_dv), 16'd0);
        check("chn err_align", 16'(err_align), 16'd1);
        check("chn err_cnt", err_cnt, CNT_EN ? 16'd1 : 16'd0);
        for (int k = 0; k < 20; k++) randomStep(1'b0, 0);
        alignedSync();
        idle(DLY + 2);
        check("resync dout_dv", 16'(dout_dv), 16'd1);
        check("resync err_align", 16'(err_align), 16'd1);

        // Random traffic with injected misalignment
        $display("[TB] random with faults");
        for (int k = 0; k < 300; k++)
            randomStep($urandom_range(0, 11) == 0,
                       ($urandom_range(0, 19) < 4) ? int'($urandom_range(1, 3)) : 0);
        alignedSync();
        for (int k = 0; k < 10; k++) randomStep(1'b0, 0);

        // Reset mid-stream
        $display("[TB] reset mid-stream");
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midreset");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("inreset");
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) randomStep(1'b0, 0);
        alignedSync();
        for (int k = 0; k < 20; k++) randomStep($urandom_range(0, 9) == 0, 0);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/prach_mixer.md
PRACH_MIXER -- requirements
Module: prach_mixer

Interface
REQ-001 Parameter DATA_DLY, default 4: data-path delay in cycles; matches upstream NCO latency.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 din_i, din_q  in  16 each  signed sample, fi(1,16,15).
REQ-005 din_dv, din_chn, sync_in  in  1/8/1  sample valid, channel tag (0-7 used), frame sync.
REQ-006 nco_cos, nco_sin  in  16 each  signed NCO output, fi(1,16,14).
REQ-007 nco_dv, nco_chn, nco_sync  in  1/8/1  NCO-side valid, channel and sync, DATA_DLY cycles behind din_*.
REQ-008 dout_i, dout_q  out  16 each  signed mixed sample, fi(1,16,15).
REQ-009 dout_dv, dout_chn, sync_out  out  1/8/1  output valid, channel and sync.
REQ-010 err_align  out  1  sticky misalignment flag.
REQ-011 err_cnt  out  16  misalignment event count.

Function
REQ-012 Data path: din_i, din_q, din_dv, din_chn and sync_in are delayed exactly DATA_DLY cycles to form d_*, aligned with nco_*.
REQ-013 Mix by e^-jphi: out_i = d_i*cos + d_q*sin; out_q = d_q*cos - d_i*sin.
REQ-014 Products are 32-bit signed and sums 33-bit signed, with no intermediate truncation.
REQ-015 Scaling: arithmetic shift right by 14, round half toward +inf (add 2^13 before the shift), then saturate to [-32768, 32767].
REQ-016 Pipeline: product register, sum register, round/saturate register; dout_* appear 3 cycles after d_*, so total latency din -> dout is DATA_DLY+3.
REQ-017 dv, chn and sync are carried through the same 3-stage pipeline as the data.
REQ-018 A mismatch occurs in any cycle where any of the following holds:
  - d_dv != nco_dv;
  - d_sync != nco_sync;
  - d_dv = nco_dv = 1 and d_chn[2:0] != nco_chn[2:0].
REQ-019 State machine has three states: WAIT_SYNC, RUN, ERR.
REQ-020 WAIT_SYNC -> RUN on a cycle with d_sync = nco_sync = 1 and no mismatch.
REQ-021 RUN -> ERR on any mismatch; a sync cycle in RUN keeps the block in RUN.
REQ-022 ERR -> RUN on an aligned sync, i.e. the same condition as REQ-020.
REQ-023 When a sync and a mismatch occur in the same cycle, the mismatch wins (-> ERR, or stay in WAIT_SYNC).
REQ-024 dout_dv is asserted only for samples whose d_dv cycle occurred in RUN or on the entering aligned-sync cycle; it is forced to 0 in WAIT_SYNC and ERR.
REQ-025 sync_out follows the pipeline from d_sync regardless of state.
REQ-026 err_align is set to 1 on the cycle after the first mismatch and stays 1 until reset; re-entering RUN does not clear it.
REQ-027 Mismatches in WAIT_SYNC are ignored: no state change, and neither err_align nor err_cnt is updated.
REQ-028 dout_i and dout_q hold their last value when the output valid is 0.

Reset
REQ-029 Assertion of rst_n is asynchronous; deassertion is synchronised to clk by the integrating design.
REQ-030 Reset values:
  - state = WAIT_SYNC;
  - all pipeline and delay stages (data, dv, chn, sync) = 0;
  - dout_i = dout_q = 0, dout_dv = 0, dout_chn = 0, sync_out = 0;
  - err_align = 0, err_cnt = 0.
REQ-031 Reset asserted mid-stream discards all in-flight samples; after release, dout_dv stays 0 until an aligned sync has been seen.

Configuration
REQ-032 Macro PRACH_MIXER_ERR_CNT_EN defined: err_cnt increments by 1 per mismatch cycle counted per REQ-027, saturates at 65535, and clears only on reset.
REQ-033 Macro undefined: the counter logic is absent, err_cnt is tied to 0, and all other behaviour is identical.

Verification
REQ-034 Pass-through: aligned sync, then d_i=16384, d_q=0, cos=16384, sin=0, chn=3 -> after DATA_DLY+3 cycles dout_i=16384, dout_q=0, dout_chn=3, dout_dv=1.
REQ-035 Saturation: d_i=d_q=32767, cos=16384, sin=-16384 -> dout_i=0, dout_q=32767 (saturated from 65534).
REQ-036 Rounding: d_i=3, d_q=0, cos=8192, sin=0 -> dout_i=2 (1.5 rounded up); d_i=-3 -> dout_i=-1.
REQ-037 Channel mismatch in RUN:
  - stimulus: nco_chn=5 while d_chn=4, one cycle;
  - response: state ERR, err_align=1, dout_dv=0 from that sample onward, err_cnt=1 (macro on) / 0 (macro off);
  - next aligned sync -> RUN, dout_dv resumes, err_align remains 1.
REQ-038 Startup: samples before the first aligned sync -> dout_dv=0 while sync_out still pulses; a sync coincident with a dv mismatch -> state remains WAIT_SYNC.
REQ-039 Reset mid-stream: rst_n low for 2 cycles during RUN -> all outputs 0 immediately; after release, no dout_dv until an aligned sync.
